// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART TX arbiter
// Contents:
//   state_t            arbiter FSM states
//   HEADER_TAG_DEFAULT default header word before the channel index is merged in
//   ch_bits()          width of a channel index for a given channel count
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        HOLD,
        FETCH,
        CAPTURE
    } state_t;

    localparam logic [7:0] HEADER_TAG_DEFAULT = 8'hF0;

    // At least one bit so a two-channel build still has a usable index.
    function automatic int ch_bits(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin picker
// Ports:
//   req    in   NUM_CH   request vector
//   last   in   CH_BITS  previously granted channel; search starts one above it
//   valid  out  1        some request is set
//   index  out  CH_BITS  winning channel
module rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = ch_bits(NUM_CH)
) (
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_BITS-1:0] last,
    output logic               valid,
    output logic [CH_BITS-1:0] index
);

    logic [CH_BITS-1:0]  start;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   rot;
    logic [CH_BITS-1:0]  off;
    logic [CH_BITS:0]    sum;

    always_comb begin
        start   = (last == CH_BITS'(NUM_CH - 1)) ? '0 : last + 1'b1;
        // Rotating a doubled copy puts the search origin at bit 0.
        req_dbl = {req, req};
        rot     = req_dbl[start +: NUM_CH];
        valid   = 1'b0;
        off     = '0;
        // Descending scan so the lowest set offset is the last one written.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                off   = CH_BITS'(k);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (CH_BITS + 1)'(NUM_CH)) begin
            sum = sum - (CH_BITS + 1)'(NUM_CH);
        end
        index = sum[CH_BITS-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter between FIFO sources
// Ports:
//   clk        in   1                  system clock
//   rst_n      in   1                  asynchronous reset, active low
//   ch_enable  in   NUM_CH             per-channel enable
//   src_din    in   NUM_CH*WORD_WIDTH  source data, valid the cycle after src_re
//   src_empty  in   NUM_CH             source FIFO empty flags
//   src_re     out  NUM_CH             one-cycle read strobe per source
//   tx_din     out  WORD_WIDTH         word offered to the transmitter
//   tx_empty   out  1                  low while tx_din holds an untaken word
//   tx_re      in   1                  transmitter read strobe
//   busy       out  1                  high outside IDLE
//   grant      out  CH_BITS            channel currently granted
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int                    NUM_CH     = 4,
    parameter int                    WORD_WIDTH = 8,
    parameter int                    MAX_BURST  = 16,
    parameter logic [WORD_WIDTH-1:0] HEADER_TAG = WORD_WIDTH'(HEADER_TAG_DEFAULT),
    localparam int                   CH_BITS    = ch_bits(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH*WORD_WIDTH-1:0] src_din,
    input  logic [NUM_CH-1:0]            src_empty,
    output logic [NUM_CH-1:0]            src_re,
    output logic [WORD_WIDTH-1:0]        tx_din,
    output logic                         tx_empty,
    input  logic                         tx_re,
    output logic                         busy,
    output logic [CH_BITS-1:0]           grant
);

    state_t                state_q, state_d;
    logic [CH_BITS-1:0]    grant_q, grant_d;
    logic [CH_BITS-1:0]    last_grant_q, last_grant_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;
    logic [WORD_WIDTH-1:0] tx_din_q, tx_din_d;

    logic [NUM_CH-1:0]     req;
    logic                  pick_valid;
    logic [CH_BITS-1:0]    pick_index;
    logic [WORD_WIDTH-1:0] src_words [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign src_words[g] = src_din[g*WORD_WIDTH +: WORD_WIDTH];
    end

    assign req = ~src_empty & ch_enable;

    rr_picker #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_picker (
        .req   (req),
        .last  (last_grant_q),
        .valid (pick_valid),
        .index (pick_index)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        tx_din_d     = tx_din_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_index;
                    tx_din_d    = {HEADER_TAG[WORD_WIDTH-1:CH_BITS], pick_index};
                    burst_cnt_d = '0;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (tx_re) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // tx_din stays put here: the transmitter samples it this cycle.
                if (burst_cnt_q == 8'(MAX_BURST) || src_empty[grant_q] || !ch_enable[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                tx_din_d    = src_words[grant_q];
                burst_cnt_d = burst_cnt_q + 8'd1;
                state_d     = PRESENT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_BITS'(NUM_CH - 1);
            burst_cnt_q  <= '0;
            tx_din_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            tx_din_q     <= tx_din_d;
        end
    end

    // Outputs decode straight from registered state so reset reaches them without a clock.
    assign tx_empty = (state_q != PRESENT);
    assign tx_din   = tx_din_q;
    assign busy     = (state_q != IDLE);
    assign grant    = grant_q;
    assign src_re   = (state_q == FETCH) ? (NUM_CH'(1) << grant_q) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NUM_CH = 4;
    localparam int WW     = 8;
    localparam int MB     = 4;
    localparam logic [7:0] HDR = 8'hF0;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_CH-1:0]      ch_enable = '0;
    logic [NUM_CH*WW-1:0]   src_din = '0;
    logic [NUM_CH-1:0]      src_empty = '1;
    logic [NUM_CH-1:0]      src_re;
    logic [WW-1:0]          tx_din;
    logic                   tx_empty;
    logic                   tx_re = 1'b0;
    logic                   busy;
    logic [1:0]             grant;

    uart_tx_arbiter #(
        .NUM_CH     (NUM_CH),
        .WORD_WIDTH (WW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_enable (ch_enable),
        .src_din   (src_din),
        .src_empty (src_empty),
        .src_re    (src_re),
        .tx_din    (tx_din),
        .tx_empty  (tx_empty),
        .tx_re     (tx_re),
        .busy      (busy),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] w;
        logic [1:0] ch;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] src_q [NUM_CH][$];
    logic [7:0] mdl_q [NUM_CH][$];
    int         mdl_last = NUM_CH - 1;
    int         n_cmp = 0;
    int         n_err = 0;
    int         budget = -1;
    bit         took = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] w, input int c);
        exp_t e;
        e.w  = w;
        e.ch = 2'(c);
        return e;
    endfunction

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            src_q[ch].push_back(b);
            mdl_q[ch].push_back(b);
        end
    endtask

    task automatic load_byte(input int ch, input logic [7:0] b);
        src_q[ch].push_back(b);
        mdl_q[ch].push_back(b);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_CH; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
        end
    endtask

    // Reference: whole grants in round-robin order over the static enable mask.
    task automatic run_model(input logic [3:0] en);
        int c;
        bit found;
        while (1) begin
            found = 1'b0;
            c = 0;
            for (int k = 1; k <= NUM_CH; k++) begin
                int j;
                j = (mdl_last + k) % NUM_CH;
                if (!found && en[j] && mdl_q[j].size() != 0) begin
                    found = 1'b1;
                    c = j;
                end
            end
            if (!found) break;
            sb.push_back(mk({HDR[7:2], 2'(c)}, c));
            for (int n = 0; n < MB && mdl_q[c].size() != 0; n++) begin
                sb.push_back(mk(mdl_q[c].pop_front(), c));
            end
            mdl_last = c;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, 32'(sb.size() == 0 && !busy), 32'd1);
    endtask

    // Source FIFO model: data appears the cycle after the read strobe.
    always @(negedge clk) begin
        if (src_re != '0) begin
            check("src_re_onehot", 32'($countones(src_re)), 32'd1);
            check("src_re_is_grant", 32'(src_re), 32'(4'(1) << grant));
            for (int i = 0; i < NUM_CH; i++) begin
                if (src_re[i]) begin
                    check("src_re_nonempty", 32'(src_q[i].size() != 0), 32'd1);
                    if (src_q[i].size() != 0) src_din[i*WW +: WW] = src_q[i].pop_front();
                end
            end
        end
        #1;
        for (int i = 0; i < NUM_CH; i++) src_empty[i] = (src_q[i].size() == 0);
    end

    // Transmitter model and scoreboard monitor.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            took  = 1'b0;
            tx_re = 1'b0;
        end else begin
            if (took) begin
                check("hold_tx_empty", 32'(tx_empty), 32'd1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", tx_din);
                end else begin
                    e = sb.pop_front();
                    check("tx_word", 32'(tx_din), 32'(e.w));
                    check("grant", 32'(grant), 32'(e.ch));
                end
            end
            if (!tx_empty) tx_re = (budget != 0) && ($urandom_range(0, 2) != 0);
            else           tx_re = ($urandom_range(0, 3) == 0);
            took = tx_re && !tx_empty;
            if (took && budget > 0) budget--;
        end
    end

    initial begin
        logic [7:0] held;
        bit         ok_e, ok_d, ok_r, busy_seen;
        int         t;
        logic [3:0] en;

        repeat (3) @(negedge clk);
        check("rst_tx_empty", 32'(tx_empty), 32'd1);
        check("rst_tx_din", 32'(tx_din), 32'd0);
        check("rst_src_re", 32'(src_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        rst_n = 1'b1;

        // Single channel with fixed bytes.
        @(negedge clk);
        ch_enable = 4'hF;
        load_byte(2, 8'h11);
        load_byte(2, 8'h22);
        run_model(4'hF);
        drain("single");

        // Round-robin across 0, 1, 3.
        @(negedge clk);
        load(0, 3); load(1, 3); load(3, 3);
        run_model(4'hF);
        drain("rr");

        // Burst limit.
        @(negedge clk);
        load(0, 10); load(1, 1);
        run_model(4'hF);
        drain("burst");

        // Stalled transmitter.
        budget = 0;
        @(negedge clk);
        load(2, 3);
        run_model(4'hF);
        t = 0;
        while (tx_empty && t < 100) begin @(negedge clk); t++; end
        check("stall_present", 32'(tx_empty), 32'd0);
        held = tx_din;
        ok_e = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (tx_empty) ok_e = 1'b0;
            if (tx_din !== held) ok_d = 1'b0;
            if (src_re != '0) ok_r = 1'b0;
        end
        check("stall_tx_empty_low", 32'(ok_e), 32'd1);
        check("stall_tx_din_stable", 32'(ok_d), 32'd1);
        check("stall_no_src_re", 32'(ok_r), 32'd1);
        budget = -1;
        drain("stall");

        // Enable drop while ch 1 presents its second data word with 5 bytes left.
        budget = 2;
        @(negedge clk);
        load(1, 7);
        sb.push_back(mk({HDR[7:2], 2'd1}, 1));
        sb.push_back(mk(mdl_q[1].pop_front(), 1));
        sb.push_back(mk(mdl_q[1].pop_front(), 1));
        mdl_last = 1;
        t = 0;
        while (!(budget == 0 && !tx_empty && !took) && t < 300) begin @(negedge clk); t++; end
        check("drop_present", 32'(budget == 0 && !tx_empty), 32'd1);
        ch_enable = 4'b1101;
        budget = -1;
        drain("drop");
        busy_seen = 1'b0;
        repeat (50) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
        check("drop_no_regrant", 32'(busy_seen), 32'd0);
        ch_enable = 4'hF;
        run_model(4'hF);
        drain("reenable");

        // Randomized phases with static enable masks.
        for (int p = 0; p < 25; p++) begin
            @(negedge clk);
            clear_all();
            en = 4'($urandom);
            for (int c = 0; c < NUM_CH; c++) load(c, int'($urandom_range(0, 9)));
            ch_enable = en;
            run_model(en);
            drain("rand");
        end

        // Asynchronous reset in FETCH.
        @(negedge clk);
        clear_all();
        ch_enable = 4'hF;
        for (int c = 0; c < NUM_CH; c++) load(c, 3);
        run_model(4'hF);
        t = 0;
        while (src_re == '0 && t < 300) begin @(negedge clk); t++; end
        check("reach_fetch", 32'(src_re != '0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_empty", 32'(tx_empty), 32'd1);
        check("arst_tx_din", 32'(tx_din), 32'd0);
        check("arst_src_re", 32'(src_re), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        @(negedge clk);
        sb.delete();
        clear_all();
        mdl_last = NUM_CH - 1;
        for (int c = 0; c < NUM_CH; c++) load(c, 3);
        run_model(4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (!busy && t < 50) begin @(negedge clk); t++; end
        check("post_reset_grant", 32'(grant), 32'd0);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
